// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : proc_pkg
//  Purpose  : Shared types and helpers for the parametrised multicycle
//             processor: opcode and state enumerations, ALU operation codes
//             and instruction-field extraction.
//  Revision : 1.0 - initial release
// ============================================================================
package proc_pkg;

  // Instruction opcodes. Codes 11..15 are not listed and decode as NOP.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_OR   = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_MV   = 4'd6,
    OP_MVI  = 4'd7,
    OP_LD   = 4'd8,
    OP_ST   = 4'd9,
    OP_MVNZ = 4'd10
  } opcode_e;

  // Control FSM states.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_IMM    = 3'd4,
    S_MEM    = 3'd5
  } state_e;

  // ALU operation codes; equal to the low three opcode bits of ALU ops.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;

  // Opcode field: ir[2*rs+3 : 2*rs].
  function automatic logic [3:0] field_op(input logic [15:0] ir, input int rs);
    logic [15:0] t;
    t = ir >> (2 * rs);
    return t[3:0];
  endfunction

  // Register field: slot 1 = X (ir[2rs-1:rs]), slot 0 = Y (ir[rs-1:0]).
  function automatic logic [3:0] field_reg(input logic [15:0] ir, input int rs,
                                           input int slot);
    logic [15:0] t;
    t = (ir >> (slot * rs)) & ((16'd1 << rs) - 16'd1);
    return t[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_multicycle_param_alu.sv
`default_nettype none
// ============================================================================
//  Module   : proc_alu
//  Purpose  : Combinational ALU for the multicycle processor.
//  Ports    : a_i, b_i  - operands (DATA_W)
//             op_i      - ALU operation code (proc_pkg ALU_*)
//             result_o  - result, wraps modulo 2^DATA_W
//  Revision : 1.0 - initial release
// ============================================================================
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int SH_W = $clog2(DATA_W);

  // Only the low clog2(DATA_W) bits of the shift operand are honoured.
  logic [SH_W-1:0] w_shamt;
  assign w_shamt = b_i[SH_W-1:0];

  always_comb begin : p_alu
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      ALU_SLL: result_o = a_i << w_shamt;
      ALU_SRL: result_o = a_i >> w_shamt;
      default: result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/proc_multicycle_param.sv
`default_nettype none
// ============================================================================
//  Module   : proc_multicycle_param
//  Purpose  : Parametrised multicycle processor with internal PC (R[NREGS-1]),
//             req/ack memory port, load/store and conditional move.
//  Ports    : clk_i, rst_i (sync, active high), run_i (allows next fetch)
//             mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_rdata_i/mem_ack_i
//             bus_wires_o (internal bus), done_o (retire pulse)
//             dbg_sel_i/dbg_data_o (combinational register read)
//             retire_cnt_o (only with PROC_RETIRE_CNT_EN defined)
//  Config   : `define PROC_RETIRE_CNT_EN adds a 32-bit retired-instruction
//             counter output.
//  Revision : 1.0 - initial release
// ============================================================================
module proc_multicycle_param
  import proc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                NREGS    = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     run_i,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [DATA_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  input  logic                     mem_ack_i,
  output logic [DATA_W-1:0]        bus_wires_o,
  output logic                     done_o,
  input  logic [$clog2(NREGS)-1:0] dbg_sel_i,
  output logic [DATA_W-1:0]        dbg_data_o
`ifdef PROC_RETIRE_CNT_EN
  ,
  output logic [31:0]              retire_cnt_o
`endif
);

  localparam int              RS     = $clog2(NREGS);
  localparam logic [RS-1:0]   c_PC   = RS'(NREGS - 1);
  localparam logic [DATA_W-1:0] c_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic              done_q;
  logic              armed_q;       // low for the first cycle after reset
  logic              fetch_pend_q;  // fetch request issued, not yet acked

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [3:0]        w_op;
  logic [3:0]        w_x_full, w_y_full;
  logic [RS-1:0]     w_x, w_y;
  logic [DATA_W-1:0] w_rx, w_ry, w_pc, w_alu_y;
  logic              w_ack, w_retire, w_unused;

  assign w_op     = field_op(ir_q[15:0], RS);
  assign w_x_full = field_reg(ir_q[15:0], RS, 1);
  assign w_y_full = field_reg(ir_q[15:0], RS, 0);
  assign w_x      = w_x_full[RS-1:0];
  assign w_y      = w_y_full[RS-1:0];
  assign w_rx     = regs_q[w_x];
  assign w_ry     = regs_q[w_y];
  assign w_pc     = regs_q[c_PC];
  assign w_unused = ^{w_x_full, w_y_full, ir_q};

  // An ack only counts while a request is outstanding.
  assign w_ack    = mem_ack_i & mem_req_o;

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (a_q),
    .b_i      (w_ry),
    .op_i     (w_op[2:0]),
    .result_o (w_alu_y)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin : p_state
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin : p_next
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (w_ack) state_d = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: state_d = S_EXEC;
          OP_MVI:                                        state_d = S_IMM;
          OP_LD, OP_ST:                                  state_d = S_MEM;
          default:                                       state_d = S_FETCH;
        endcase
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_IMM:    if (w_ack) state_d = S_FETCH;
      S_MEM:    if (w_ack) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Any return to FETCH from another state retires an instruction.
  assign w_retire = (state_q != S_FETCH) && (state_d == S_FETCH);

  // --------------------------------------------------------------------------
  // FSM: outputs (memory port)
  // --------------------------------------------------------------------------
  always_comb begin : p_outputs
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = w_pc;
    mem_wdata_o = '0;
    case (state_q)
      // Once raised, the fetch request is held until acked even if Run drops.
      S_FETCH: mem_req_o = armed_q & (run_i | fetch_pend_q);
      S_IMM:   mem_req_o = 1'b1;
      S_MEM: begin
        mem_req_o  = 1'b1;
        mem_addr_o = w_ry;
        if (w_op == OP_ST) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = w_rx;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath control and internal bus
  // --------------------------------------------------------------------------
  logic              w_wr_en, w_pc_inc;
  logic [DATA_W-1:0] w_wr_data, w_bus;

  always_comb begin : p_datapath
    ir_d      = ir_q;
    a_d       = a_q;
    g_d       = g_q;
    w_wr_en   = 1'b0;
    w_wr_data = '0;
    w_pc_inc  = 1'b0;
    w_bus     = '0;
    case (state_q)
      S_FETCH: begin
        if (w_ack) begin
          w_bus    = mem_rdata_i;
          ir_d     = mem_rdata_i;
          w_pc_inc = 1'b1;
        end
      end
      S_DECODE: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: begin
            w_bus = w_rx;
            a_d   = w_rx;
          end
          OP_MV: begin
            w_bus     = w_ry;
            w_wr_en   = 1'b1;
            w_wr_data = w_ry;
          end
          OP_MVNZ: begin
            w_bus     = w_ry;
            w_wr_en   = (g_q != '0);
            w_wr_data = w_ry;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        w_bus = w_ry;
        g_d   = w_alu_y;
      end
      S_WB: begin
        w_bus     = g_q;
        w_wr_en   = 1'b1;
        w_wr_data = g_q;
      end
      S_IMM: begin
        if (w_ack) begin
          w_bus     = mem_rdata_i;
          w_wr_en   = 1'b1;
          w_wr_data = mem_rdata_i;
          // A load of the immediate into the PC is a jump; no increment.
          w_pc_inc  = (w_x != c_PC);
        end
      end
      S_MEM: begin
        if (w_op == OP_ST) begin
          w_bus = w_rx;
        end else if (w_ack) begin
          w_bus     = mem_rdata_i;
          w_wr_en   = 1'b1;
          w_wr_data = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin : p_regs
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == NREGS - 1) ? RESET_PC : '0;
      end
      ir_q         <= '0;
      a_q          <= '0;
      g_q          <= '0;
      done_q       <= 1'b0;
      armed_q      <= 1'b0;
      fetch_pend_q <= 1'b0;
    end else begin
      if (w_pc_inc) regs_q[c_PC] <= w_pc + c_ONE;
      // Placed after the increment so that a register write always wins.
      if (w_wr_en)  regs_q[w_x]  <= w_wr_data;
      ir_q         <= ir_d;
      a_q          <= a_d;
      g_q          <= g_d;
      done_q       <= w_retire;
      armed_q      <= 1'b1;
      fetch_pend_q <= (state_q == S_FETCH) & mem_req_o & ~w_ack;
    end
  end

  assign bus_wires_o = w_bus;
  assign done_o      = done_q;
  assign dbg_data_o  = regs_q[dbg_sel_i];

`ifdef PROC_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk_i) begin : p_retire_cnt
    if (rst_i)       retire_cnt_q <= '0;
    else if (done_q) retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  assign retire_cnt_o = retire_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_proc_multicycle_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_proc_multicycle_param
//  Purpose  : Directed self-checking testbench for proc_multicycle_param
//             (DATA_W=16, NREGS=8, RESET_PC=0) with a req/ack RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_multicycle_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_en = 1'b0;
  logic        run;
  logic        mem_req, mem_we, mem_ack, done;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, bus_wires, dbg_data;
  logic [2:0]  dbg_sel = 3'd7;
  logic [15:0] stop_pc = 16'hFFFF;
`ifdef PROC_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Run is released until the PC (dbg_sel held at 7 while running) hits stop_pc.
  assign run = run_en && (dbg_data != stop_pc);

  proc_multicycle_param #(.DATA_W(16), .NREGS(8), .RESET_PC(16'h0000)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .run_i       (run),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .bus_wires_o (bus_wires),
    .done_o      (done),
    .dbg_sel_i   (dbg_sel),
    .dbg_data_o  (dbg_data)
`ifdef PROC_RETIRE_CNT_EN
    ,
    .retire_cnt_o(retire_cnt)
`endif
  );

  // --------------------------------------------------------------------------
  // RAM model: ack after 'lat' wait cycles; force_ack injects a stray ack.
  // --------------------------------------------------------------------------
  logic [15:0] mem [0:255];
  int          lat = 0;
  int          wait_cnt = 0;
  logic        ack_en = 1'b1;
  logic        force_ack = 1'b0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [15:0] ld_data = 16'd0;

  assign mem_ack   = force_ack | (ack_en & mem_req & (wait_cnt >= lat));
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // --------------------------------------------------------------------------
  // Observers (sampled on the falling edge)
  // --------------------------------------------------------------------------
  int          done_t [$];
  logic [15:0] rd_addrs [$];
  int          st_seen = 0;
  logic [15:0] st_addr = 16'd0, st_data = 16'd0;
  int          stab_err = 0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr = 16'd0, prev_wd = 16'd0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (done) done_t.push_back(cyc);
    if (mem_req && mem_ack && !mem_we) rd_addrs.push_back(mem_addr);
    if (mem_req && mem_ack && mem_we) begin
      st_seen <= st_seen + 1;
      st_addr <= mem_addr;
      st_data <= mem_wdata;
    end
    if (!rst && prev_wait &&
        (!mem_req || mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wd))
      stab_err <= stab_err + 1;
    prev_wait <= mem_req && !mem_ack && !rst;
    prev_addr <= mem_addr;
    prev_we   <= mem_we;
    prev_wd   <= mem_wdata;
  end

  // --------------------------------------------------------------------------
  // Helpers (stimulus only)
  // --------------------------------------------------------------------------
  task automatic load(input int a, input logic [15:0] d);
    @(negedge clk);
    ld_addr = 8'(a);
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    run_en = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd(input int idx, output logic [15:0] v);
    dbg_sel = 3'(idx);
    #1;
    v = dbg_data;
  endtask

  // Runs until ndone retirements are seen (bounded), then parks the core.
  task automatic run_prog(input logic [15:0] stop, input int ndone,
                          output int t0, output int base);
    int k;
    base = done_t.size();
    @(negedge clk);
    stop_pc = stop;
    dbg_sel = 3'd7;
    run_en  = 1'b1;
    t0      = cyc;
    k       = 0;
    while ((done_t.size() - base) < ndone && k < 2000) begin
      @(negedge clk);
      k++;
    end
    run_en = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (done_t.size() - base != ndone) begin
      errors++;
      $display("FAIL run_done_count: got %0d, expected %0d", done_t.size() - base, ndone);
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [15:0] v;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b done=%b, expected 0 0 0", mem_req, mem_we, done);
    end
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      checks++;
      if (v !== 16'h0000) begin
        errors++;
        $display("FAIL reset_reg R%0d: got %h, expected 0000", i, v);
      end
    end
    @(negedge clk);
  endtask

  task automatic load_add_prog();
    load(0, 16'h01C0); load(1, 16'h0005);
    load(2, 16'h01C8); load(3, 16'h0003);
    load(4, 16'h0001);
  endtask

  task automatic check_add_result(input string tag);
    logic [15:0] v;
    rd(0, v); checks++;
    if (v !== 16'h0008) begin errors++; $display("FAIL %s R0: got %h, expected 0008", tag, v); end
    rd(1, v); checks++;
    if (v !== 16'h0003) begin errors++; $display("FAIL %s R1: got %h, expected 0003", tag, v); end
    rd(7, v); checks++;
    if (v !== 16'h0005) begin errors++; $display("FAIL %s PC: got %h, expected 0005", tag, v); end
  endtask

  task automatic test_zero_wait();
    int t0, b;
    lat = 0;
    load_add_prog();
    run_prog(16'h0005, 3, t0, b);
    check_add_result("zw");
    if (done_t.size() >= b + 3) begin
      checks++;
      if (done_t[b] - t0 != 3) begin
        errors++; $display("FAIL zw_spacing1: got %0d, expected 3", done_t[b] - t0);
      end
      checks++;
      if (done_t[b+1] - done_t[b] != 3) begin
        errors++; $display("FAIL zw_spacing2: got %0d, expected 3", done_t[b+1] - done_t[b]);
      end
      checks++;
      if (done_t[b+2] - done_t[b+1] != 4) begin
        errors++; $display("FAIL zw_spacing3: got %0d, expected 4", done_t[b+2] - done_t[b+1]);
      end
    end
  endtask

  task automatic test_wait_states();
    int t0, b, s0;
    do_reset();
    lat = 3;
    s0  = stab_err;
    run_prog(16'h0005, 3, t0, b);
    check_add_result("ws");
    checks++;
    if (stab_err - s0 != 0) begin
      errors++; $display("FAIL ws_req_stable: got %0d violations, expected 0", stab_err - s0);
    end
    lat = 0;
  endtask

  task automatic test_ld_st();
    int t0, b, s0;
    logic [15:0] v;
    do_reset();
    load(0, 16'h01D0); load(1, 16'h0010);   // MVI R2,#0x0010
    load(2, 16'h01D8); load(3, 16'hABCD);   // MVI R3,#0xABCD
    load(4, 16'h025A);                      // ST  R3,R2
    load(5, 16'h0222);                      // LD  R4,R2
    s0 = st_seen;
    run_prog(16'h0006, 4, t0, b);
    checks++;
    if (st_seen - s0 != 1) begin
      errors++; $display("FAIL st_count: got %0d, expected 1", st_seen - s0);
    end
    checks++;
    if (st_addr !== 16'h0010 || st_data !== 16'hABCD) begin
      errors++; $display("FAIL st_write: got addr %h data %h, expected 0010 ABCD", st_addr, st_data);
    end
    rd(4, v); checks++;
    if (v !== 16'hABCD) begin errors++; $display("FAIL ld_R4: got %h, expected ABCD", v); end
  endtask

  task automatic test_mvnz();
    int t0, b;
    logic [15:0] v;
    do_reset();
    load(0, 16'h01C0); load(1, 16'h0007);   // MVI R0,#7
    load(2, 16'h01C8); load(3, 16'h0009);   // MVI R1,#9
    load(4, 16'h0052);                      // SUB R2,R2  -> G=0
    load(5, 16'h0281);                      // MVNZ R0,R1 (not taken)
    load(6, 16'h01D8); load(7, 16'h0001);   // MVI R3,#1
    load(8, 16'h0013);                      // ADD R2,R3  -> G=1
    load(9, 16'h02A1);                      // MVNZ R4,R1 (taken)
    run_prog(16'h000A, 7, t0, b);
    rd(0, v); checks++;
    if (v !== 16'h0007) begin errors++; $display("FAIL mvnz_zero R0: got %h, expected 0007", v); end
    rd(4, v); checks++;
    if (v !== 16'h0009) begin errors++; $display("FAIL mvnz_taken R4: got %h, expected 0009", v); end
    rd(2, v); checks++;
    if (v !== 16'h0001) begin errors++; $display("FAIL add_R2: got %h, expected 0001", v); end
  endtask

  task automatic test_jump_srl();
    int t0, b, a0;
    logic [15:0] v;
    do_reset();
    load(0,     16'h01F8); load(1,     16'h0020);   // MVI R7,#0x0020
    load(8'h20, 16'h01E8); load(8'h21, 16'h8000);   // MVI R5,#0x8000
    load(8'h22, 16'h01F0); load(8'h23, 16'h0011);   // MVI R6,#0x0011
    load(8'h24, 16'h016E);                          // SRL R5,R6
    a0 = rd_addrs.size();
    run_prog(16'h0025, 4, t0, b);
    checks++;
    if (rd_addrs.size() < a0 + 3) begin
      errors++; $display("FAIL jump_fetch: got %0d reads, expected at least 3", rd_addrs.size() - a0);
    end else if (rd_addrs[a0+2] !== 16'h0020) begin
      errors++; $display("FAIL jump_fetch: got addr %h, expected 0020", rd_addrs[a0+2]);
    end
    rd(5, v); checks++;
    if (v !== 16'h4000) begin errors++; $display("FAIL srl_R5: got %h, expected 4000", v); end
    rd(7, v); checks++;
    if (v !== 16'h0025) begin errors++; $display("FAIL jump_PC: got %h, expected 0025", v); end
  endtask

  task automatic test_reset_midreq();
    int k, d0;
    logic [15:0] v;
    // Continues from the previous test: PC=0x25, R5=0x4000.
    @(negedge clk);
    ack_en  = 1'b0;
    stop_pc = 16'hFFFF;
    dbg_sel = 3'd7;
    run_en  = 1'b1;
    k = 0;
    while (!mem_req && k < 20) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0025) begin
      errors++; $display("FAIL midreq_hold: got req=%b addr=%h, expected 1 0025", mem_req, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midreq_reset: got req=%b we=%b done=%b, expected 0 0 0", mem_req, mem_we, done);
    end
    run_en = 1'b0;
    rst    = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    d0 = done_t.size();
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    repeat (3) @(negedge clk);
    rd(7, v); checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL late_ack_PC: got %h, expected 0000", v); end
    rd(5, v); checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL midreq_R5: got %h, expected 0000", v); end
    checks++;
    if (done_t.size() != d0) begin
      errors++; $display("FAIL late_ack_done: got %0d pulses, expected 0", done_t.size() - d0);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_ld_st();
    test_mvnz();
    test_jump_srl();
    test_reset_midreq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/proc_multicycle_param.md
Name: proc_multicycle_param

Overview:
- Parametrised successor to the fixed 16-bit, 8-register multicycle processor.
- Adds an internal PC, mapped onto the top register, and fetches through a req/ack memory port instead of an external ROM counter.
- Adds load, store and conditional move.
- Sits between the instruction/data RAM and the board top level; register contents are observed through a debug read port.

Parameters:
- DATA_W, 16, datapath and memory word width (min 16).
- NREGS, 8, number of general registers, power of two, 4..16. R[NREGS-1] is the PC.
- RESET_PC, 0, PC value after reset.

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  permits fetch of the next instruction.
- mem_req  out  1  memory request, held until acked.
- mem_we  out  1  1 = write (store), 0 = read.
- mem_addr  out  DATA_W  word address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- mem_ack  in  1  request complete; may arrive in the same cycle as mem_req.
- BusWires  out  DATA_W  internal bus value (debug).
- Done  out  1  one-cycle pulse per retired instruction.
- dbg_sel  in  clog2(NREGS)  debug register select.
- dbg_data  out  DATA_W  combinational R[dbg_sel].

Behaviour:
- Encoding, with RS = clog2(NREGS), in IR low bits:
  - [2RS+3:2RS] = op, [2RS-1:RS] = X, [RS-1:0] = Y.
  - op codes: 0 ADD, 1 SUB, 2 OR, 3 SLT (unsigned, result 1/0), 4 SLL, 5 SRL, 6 MV, 7 MVI, 8 LD, 9 ST, 10 MVNZ, 11-15 NOP.
- Arithmetic wraps modulo 2^DATA_W. Shift amount = Ry[clog2(DATA_W)-1:0]. SLT/SLL/SRL write Rx.
- State machine: FETCH, DECODE, EXEC, WB, IMM, MEM.
- FETCH:
  - Run=0: idle, mem_req=0.
  - Run=1: mem_req=1, addr=PC, we=0.
  - On ack: IR<=rdata, PC<=PC+1, go DECODE.
- DECODE:
  - ALU ops: A<=Rx, go EXEC.
  - MV: Rx<=Ry, retire.
  - MVNZ: if G!=0 then Rx<=Ry; retire either way.
  - MVI: go IMM.
  - LD/ST: go MEM.
  - NOP: retire.
- EXEC: G<=A op Ry, go WB.
- WB: Rx<=G, retire.
- IMM: req at addr=PC. On ack: Rx<=rdata, PC<=PC+1 unless X=NREGS-1 (register write wins), retire.
- MEM:
  - LD: addr=Ry, we=0; on ack Rx<=rdata, retire.
  - ST: addr=Ry, wdata=Rx, we=1; on ack retire.
- Retire means return to FETCH and set Done=1 in the following cycle, for exactly one cycle.
- Handshake:
  - While mem_req=1, addr/we/wdata are stable until the ack cycle.
  - mem_req drops the cycle after ack.
  - mem_ack with mem_req=0 is ignored.
- Run is sampled only in FETCH; deasserting it mid-instruction completes the current instruction.
- Any write to R[NREGS-1] is a jump.
- G holds the last ALU result; MVNZ tests it.
- Cycle counts with zero-wait memory (ack in the req cycle):
  - ALU op: 4.
  - MV/MVNZ/NOP: 2.
  - MVI/LD/ST: 3.
- Reset, at any time including mid-request:
  - state=FETCH, mem_req=0, mem_we=0, Done=0.
  - all registers, A, G and IR = 0; PC=RESET_PC.
  - In-flight memory transaction is abandoned.
- BusWires reflects the selected source each cycle; it is 0 when no source is selected.

Optional Feature:
- Macro: PROC_RETIRE_CNT_EN.
- Defined: adds output retire_cnt (32 bits), cleared on Reset, incremented on each Done pulse, wraps at 2^32.
- Undefined: the port and counter do not exist; nothing else changes.

Decomposition:
- Shared package proc_pkg holds:
  - opcode enum (4 bits).
  - state enum.
  - ALU op constants.
  - function for field extraction given RS.
- One sub-module, proc_alu: combinational, parametrised by DATA_W, inputs A/B/op, output result.
- Register file, control FSM and bus mux stay in the top module.

Test Plan:
- Reset, Run=1, zero-wait RAM holding 0x1C0, 0x0005, 0x1C8, 0x0003, 0x001 (MVI R0,#5; MVI R1,#3; ADD R0,R1) -> R0=8, R1=3, PC=5, three Done pulses. Done spacing 3, 3, 4 cycles.
- RAM with 3-cycle ack delay, same program -> identical final registers; mem_addr/mem_req stable for the whole wait.
- LD/ST: R2=0x0010, R3=0xABCD, ST R3,R2 then LD R4,R2 -> write of 0xABCD at 0x10 with mem_we=1, then R4=0xABCD.
- MVNZ after SUB R0,R0 (G=0) -> destination unchanged. After ADD giving G=1 -> destination loaded.
- MVI R7,#0x0020 -> next fetch address 0x0020, not 0x0002. SRL with Ry=0x0011 at DATA_W=16 -> shift by 1.
- Reset asserted while mem_req=1 awaiting ack -> next cycle mem_req=0, all registers 0, PC=RESET_PC. A late ack is ignored.
